dpram_client_ctrl: RTL



---
 rtl/dpram_client_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dpram_client_ctrl.sv
// dpram_client_ctrl: two-client front end for the 4x4-bit dual-port register RAM.
// Clients A and B issue independent read/write requests. Writes are mapped onto
// the RAM's single 2-bit write-code port. Two writes to different addresses are
// split across two cycles, and client B's write is the one that is deferred.
// Read data comes back one cycle after acceptance and is held in registers.
//
// Handshake: a request is accepted on a rising clck edge when req_valid_x and
// req_ready_x are both 1. req_ready_x depends only on the controller state and
// on rst, never on req_valid_x. Responses have no backpressure: rsp_valid_x is
// a one-cycle pulse, and rsp_data_x holds its value until the next response.
module dpram_client_ctrl (
    input  logic        clck,
    input  logic        rst,
    input  logic        req_valid_a,
    input  logic        req_valid_b,
    output logic        req_ready_a,
    output logic        req_ready_b,
    input  logic        req_we_a,
    input  logic        req_we_b,
    input  logic [1:0]  req_addr_a,
    input  logic [1:0]  req_addr_b,
    input  logic [3:0]  req_wdata_a,
    input  logic [3:0]  req_wdata_b,
    output logic        rsp_valid_a,
    output logic        rsp_valid_b,
    output logic [3:0]  rsp_data_a,
    output logic [3:0]  rsp_data_b,
    output logic [1:0]  ram_address,
    output logic [1:0]  ram_write,
    output logic [3:0]  ram_data_a,
    output logic [3:0]  ram_data_b,
    output logic        ram_read_a,
    output logic        ram_read_b,
    output logic [1:0]  ram_address_read_a,
    output logic [1:0]  ram_address_read_b,
    input  logic [15:0] ram_data_out_a,
    input  logic [15:0] ram_data_out_b,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  pend_addr;
    logic [3:0]  pend_data;

    logic        acc_a;
    logic        acc_b;
    logic        wr_a;
    logic        wr_b;
    logic        rd_a;
    logic        rd_b;
    logic        split_wr;

    // Both clients are stalled while a deferred write is in flight, and while reset is held.
    assign req_ready_a = rst & (state == IDLE);
    assign req_ready_b = rst & (state == IDLE);

    assign acc_a    = req_valid_a & req_ready_a;
    assign acc_b    = req_valid_b & req_ready_b;
    assign wr_a     = acc_a & req_we_a;
    assign wr_b     = acc_b & req_we_b;
    assign rd_a     = acc_a & ~req_we_a;
    assign rd_b     = acc_b & ~req_we_b;
    assign split_wr = wr_a & wr_b & (req_addr_a != req_addr_b);

    assign state_dbg = (state == PEND);

    // State register.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: PEND lasts exactly one cycle, and only after a split write.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (split_wr) state_next = PEND;
            PEND:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture client B's half of a split write. Reset drops it.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            pend_addr <= 2'b00;
            pend_data <= 4'h0;
        end else if (split_wr) begin
            pend_addr <= req_addr_b;
            pend_data <= req_wdata_b;
        end
    end

    // Registered read responses. The RAM bus still shows the pre-write word at the acceptance edge.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            rsp_valid_a <= 1'b0;
            rsp_valid_b <= 1'b0;
            rsp_data_a  <= 4'h0;
            rsp_data_b  <= 4'h0;
        end else begin
            rsp_valid_a <= rd_a;
            rsp_valid_b <= rd_b;
            if (rd_a) rsp_data_a <= ram_data_out_a[{req_addr_a, 2'b00} +: 4];
            if (rd_b) rsp_data_b <= ram_data_out_b[{req_addr_b, 2'b00} +: 4];
        end
    end

    // RAM drive: write code, write address and data lanes, plus both read ports.
    always_comb begin
        ram_write          = 2'b00;
        ram_address        = 2'b00;
        ram_data_a         = 4'h0;
        ram_data_b         = 4'h0;
        ram_read_a         = 1'b0;
        ram_read_b         = 1'b0;
        ram_address_read_a = 2'b00;
        ram_address_read_b = 2'b00;

        if (state == PEND) begin
            ram_write   = 2'b01;
            ram_address = pend_addr;
            ram_data_b  = pend_data;
        end else begin
            if (wr_a && wr_b) begin
                ram_address = req_addr_a;
                ram_data_a  = req_wdata_a;
                if (req_addr_a == req_addr_b) begin
                    // The RAM comparator outputs 0 when the two words are equal,
                    // so the merge code is only used when the data differ.
                    ram_data_b = req_wdata_b;
                    ram_write  = (req_wdata_a != req_wdata_b) ? 2'b11 : 2'b10;
                end else begin
                    ram_write = 2'b10;
                end
            end else if (wr_a) begin
                ram_write   = 2'b10;
                ram_address = req_addr_a;
                ram_data_a  = req_wdata_a;
            end else if (wr_b) begin
                ram_write   = 2'b01;
                ram_address = req_addr_b;
                ram_data_b  = req_wdata_b;
            end

            if (rd_a) begin
                ram_read_a         = 1'b1;
                ram_address_read_a = req_addr_a;
            end
            if (rd_b) begin
                ram_read_b         = 1'b1;
                ram_address_read_b = req_addr_b;
            end
        end
    end

endmodule
